// File: rtl/icache_data_ctrl_pkg.sv
// icache_data_ctrl_pkg: shared geometry and byte-mask helper for the icache data controller
// Geometry: 32 lines x 256 b array, 64 b refill beats (4 beats/line), byte write mask.
package icache_data_ctrl_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int STARVE_MAX = 4;
    localparam int MASK_WIDTH = LINE_WIDTH / 8;
    localparam int BEAT_BYTES = BEAT_WIDTH / 8;
    localparam int BEAT_CNT_W = $clog2(BEATS);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    // Byte-enable mask selecting the lanes of one refill beat within the line.
    function automatic logic [MASK_WIDTH-1:0] beat_wmask(input logic [BEAT_CNT_W-1:0] beat);
        return MASK_WIDTH'({BEAT_BYTES{1'b1}}) << (BEAT_BYTES * int'(beat));
    endfunction
endpackage

// File: rtl/icache_data_ctrl_if.sv
// icache_data_ctrl_if: fetch-read and refill-write handshakes between tag/miss FSM and data controller
// master: tag/miss FSM side (drives requests and refill beats)
// slave : data controller side (returns grants, read data, fill status)
interface icache_data_ctrl_if;
    import icache_data_ctrl_pkg::*;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_rvalid;
    logic [LINE_WIDTH-1:0] rd_rdata;
    logic                  fill_valid;
    logic                  fill_ready;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [BEAT_WIDTH-1:0] fill_data;
    logic                  fill_last;
    logic                  fill_done;
    logic                  protocol_err;

    modport master (
        output rd_req, rd_addr, fill_valid, fill_addr, fill_data, fill_last,
        input  rd_gnt, rd_rvalid, rd_rdata, fill_ready, fill_done, protocol_err
    );
    modport slave (
        input  rd_req, rd_addr, fill_valid, fill_addr, fill_data, fill_last,
        output rd_gnt, rd_rvalid, rd_rdata, fill_ready, fill_done, protocol_err
    );
endinterface

// File: rtl/icache_data_ctrl_fill_seq.sv
// icache_data_ctrl_fill_seq: refill beat sequencer (beat count, line capture, write mask/data, status)
// Ports:
//   clk, rst_n        clock, async active-low reset
//   fill_gnt          refill beat accepted this cycle
//   fill_addr/data/last  beat address (used on beat 0 only), payload, last marker
//   beat_cnt          index of the next beat to be written
//   fill_line         line captured on beat 0
//   wr_addr/mask/data array address, byte mask and replicated data for the current beat
//   fill_done         1-cycle pulse after the final beat is accepted
//   protocol_err      sticky: fill_last not coincident with the final beat
module icache_data_ctrl_fill_seq
    import icache_data_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_gnt,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [BEAT_WIDTH-1:0] fill_data,
    input  logic                  fill_last,
    output logic [BEAT_CNT_W-1:0] beat_cnt,
    output logic [ADDR_WIDTH-1:0] fill_line,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [MASK_WIDTH-1:0] wr_mask,
    output logic [LINE_WIDTH-1:0] wr_data,
    output logic                  fill_done,
    output logic                  protocol_err
);
    logic last_beat;
    logic term;

    assign last_beat = beat_cnt == BEAT_CNT_W'(BEATS - 1);
    // Either marker ends the line; a disagreement between them is a protocol error.
    assign term      = fill_last || last_beat;
    assign wr_addr   = beat_cnt == '0 ? fill_addr : fill_line;
    assign wr_mask   = beat_wmask(beat_cnt);
    assign wr_data   = {BEATS{fill_data}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt     <= '0;
            fill_line    <= '0;
            fill_done    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            fill_done <= fill_gnt && term;
            if (fill_gnt) begin
                beat_cnt <= term ? '0 : beat_cnt + 1'b1;
                if (beat_cnt == '0)
                    fill_line <= fill_addr;
                if (fill_last != last_beat)
                    protocol_err <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/icache_data_ctrl.sv
// icache_data_ctrl: single-port icache data array owner arbitrating fetch reads against refill writes
// Ports:
//   clk, rst_n     clock, async active-low reset
//   bus            slave side of the read/refill handshakes
//   sram_csb/web   array chip select / write enable, active low
//   sram_wmask     byte write mask
//   sram_addr/din  array address / write data
//   sram_dout      array read data (valid the cycle after a read grant)
module icache_data_ctrl
    import icache_data_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    icache_data_ctrl_if.slave     bus,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [MASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [LINE_WIDTH-1:0] sram_din,
    input  logic [LINE_WIDTH-1:0] sram_dout
);
    logic [STARVE_W-1:0]   starve_cnt;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [ADDR_WIDTH-1:0] fill_line;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [MASK_WIDTH-1:0] wr_mask;
    logic                  hazard;
    logic                  rd_win;
    logic                  fill_gnt;
    logic                  rd_rvalid;
    logic                  fill_done;
    logic                  protocol_err;

    // A read of the line being refilled must wait for the whole line, even when starved.
    assign hazard   = bus.rd_req && beat_cnt != '0 && bus.rd_addr == fill_line;
    // Refill has priority unless the read has been starved long enough; grants are
    // forced off while reset is asserted so the array stays deselected.
    assign rd_win   = rst_n && bus.rd_req && !hazard &&
                      (!bus.fill_valid || starve_cnt == STARVE_W'(STARVE_MAX));
    assign fill_gnt = bus.fill_valid && bus.fill_ready;

    assign bus.rd_gnt       = rd_win;
    assign bus.fill_ready   = rst_n && !rd_win;
    assign bus.rd_rvalid    = rd_rvalid;
    assign bus.rd_rdata     = rd_rvalid ? sram_dout : '0;
    assign bus.fill_done    = fill_done;
    assign bus.protocol_err = protocol_err;

    assign sram_csb   = !(rd_win || fill_gnt);
    assign sram_web   = !fill_gnt;
    assign sram_wmask = fill_gnt ? wr_mask : '0;
    assign sram_addr  = fill_gnt ? wr_addr : bus.rd_addr;

    icache_data_ctrl_fill_seq u_fill_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .fill_gnt     (fill_gnt),
        .fill_addr    (bus.fill_addr),
        .fill_data    (bus.fill_data),
        .fill_last    (bus.fill_last),
        .beat_cnt     (beat_cnt),
        .fill_line    (fill_line),
        .wr_addr      (wr_addr),
        .wr_mask      (wr_mask),
        .wr_data      (sram_din),
        .fill_done    (fill_done),
        .protocol_err (protocol_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            rd_rvalid  <= 1'b0;
        end else begin
            rd_rvalid <= rd_win;
            if (rd_win)
                starve_cnt <= '0;
            else if (bus.rd_req && starve_cnt != STARVE_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule
